hilo_muldiv_unit: RTL
=====================

// Module: hilo_muldiv_unit
// PURPOSE
//  Producer end of the HI/LO datapath: executes MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from EX.
//  Owns the architectural HI/LO registers and drives the stall that holds the pipeline while a
//  result is pending, so downstream mfhi/mflo readers never need HI/LO forwarding.
//  Sits beside the ALU in EX; the core stall/flush logic consumes stall_o.
// PARAMETERS
//  DATA_W     32  operand / HI / LO width (only 32 is supported)
//  MUL_LAT    2   cycles from accept to HI/LO update for MULT/MULTU (>=1)
// PORTS
//  clk        in   1       clock, all state updates on rising edge
//  reset      in   1       synchronous, active-high
//  ex_valid   in   1       EX holds a valid HI/LO-class op; held stable while stall_o=1
//  ex_op      in   3       op code (hilo_defs.vh): NONE,MULT,MULTU,DIV,DIVU,MTHI,MTLO
//  ex_src_a   in   DATA_W  rs value (multiplicand / dividend / MTHI/MTLO data)
//  ex_src_b   in   DATA_W  rt value (multiplier / divisor)
//  ex_cancel  in   1       flush/exception kill of the EX op; aborts any operation in flight
//  stall_o    out  1       hold IF/ID/EX; combinational from ex_valid, ex_op and state
//  busy_o     out  1       FSM not IDLE (registered)
//  hi_o       out  DATA_W  architectural HI (registered)
//  lo_o       out  DATA_W  architectural LO (registered)
// BEHAVIOUR
//  Reset: state=IDLE, HI=LO=0, counter=0, busy_o=0, stall_o=0 (regardless of inputs).
//  Accept: cycle T with state=IDLE, ex_valid=1, ex_cancel=0, op in {MULT,MULTU,DIV,DIVU}.
//  FSM: IDLE -> MUL -> IDLE ; IDLE -> DIV_INIT -> DIV_ITER(x32) -> DIV_FIX -> IDLE.
//   MUL: stays MUL_LAT-1 cycles; 64-bit product (signed for MULT) -> HI=[63:32], LO=[31:0].
//   DIV_INIT: latch |a|,|b| (abs only for DIV), sign flags; counter=0.
//   DIV_ITER: radix-2 restoring step per cycle, counter 0..31, leaves after counter=31.
//   DIV_FIX: negate quotient if signs differ; remainder takes dividend sign; write LO=q, HI=r.
//  Latency L: MUL_LAT for multiply, 34 for divide. stall_o=1 in cycles T..T+L-1; new HI/LO
//   visible on hi_o/lo_o from cycle T+L; stall_o=0 in T+L so the op leaves EX then.
//  stall_o = ex_valid & ~ex_cancel & ((IDLE & op is mul/div) | (~IDLE & ~finishing)).
//  MTHI/MTLO: IDLE only, no stall; HI (or LO) = ex_src_a visible next cycle.
//  NONE or ex_valid=0 in IDLE: no state change, stall_o=0.
//  Divide by zero: no trap; result of restoring algorithm: DIVU q=0xFFFFFFFF, r=a;
//   DIV applies sign fix to those values. 0x80000000 DIV -1 -> LO=0x80000000, HI=0.
//  ex_cancel=1 in any state: next state IDLE, HI/LO unchanged, stall_o=0 same cycle.
//   Cancel in the finishing cycle (last MUL cycle / DIV_FIX) also suppresses the write.
//  Reset mid-operation: identical to power-on reset; no partial HI/LO write.
//  Ops arriving while ~IDLE are impossible (pipeline stalled); any ex_op change while
//   busy is a protocol violation (bench assertion), RTL ignores it.
// STRUCTURE
//  hilo_defs.vh: op code localparams (3-bit), state encodings, DIV_STEPS=32.
//  Sub-module div_iter_core: restoring divider datapath (init/step/fix controls,
//   64-bit partial remainder, quotient shift reg); FSM and HI/LO regs stay in top.
//  Multiplier: behavioural '*' into a MUL_LAT-1 deep register pipe.
// TESTING
//  1 MULT a=0xFFFFFFFE b=3 -> stall_o high 2 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFA.
//  2 DIVU 100/7 -> stall_o high exactly 34 cycles, then LO=14 HI=2; busy_o low after.
//  3 DIV -7/2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF; DIV 0x80000000/-1 -> LO=0x80000000 HI=0.
//  4 DIVU 5/0 -> LO=0xFFFFFFFF HI=5; DIV -5/0 -> LO=1 HI=0xFFFFFFFB.
//  5 DIV started, ex_cancel at iteration 10 -> HI/LO unchanged, stall_o=0 that cycle,
//    MTLO 0x1234 next cycle -> LO=0x1234 one cycle later.
//  6 reset asserted during DIV_ITER -> HI=LO=0, busy_o=0 next cycle; MTHI 0xA5A5A5A5 -> hi_o.

Source files
------------

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM
// states, divider step count and small two's-complement helpers.
package hilo_muldiv_unit_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = 8;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } hilo_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL      = 3'd1,
        ST_DIV_INIT = 3'd2,
        ST_DIV_ITER = 3'd3,
        ST_DIV_FIX  = 3'd4
    } hilo_state_e;

    // Two's-complement negation of a full-width word.
    function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v);
        return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of v when treated as signed (en=1), else v unchanged.
    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude for the divider.
    function automatic logic [XLEN-1:0] abs_word(input logic [XLEN-1:0] v,
                                                 input logic            en);
        return (en && v[XLEN-1]) ? neg_word(v) : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_div_iter_core.sv
// Radix-2 restoring divider datapath. The upper half of the 64-bit partial
// remainder holds the running remainder; the lower half shifts the dividend
// out and the quotient bits in. Sign correction is applied on the outputs.
module hilo_muldiv_unit_div_iter_core
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_init,
    input  logic              i_step,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_quot,
    output logic [DATA_W-1:0] o_rem
);

    logic [2*DATA_W-1:0] r_pr;
    logic [DATA_W-1:0]   r_dvs;
    logic                r_neg_q;
    logic                r_neg_r;

    logic [DATA_W:0]     w_up;
    logic [DATA_W+1:0]   w_diff;
    logic                w_ge;

    // Shifted remainder (33 bits) and trial subtraction of the divisor.
    always_comb begin
        w_up   = r_pr[2*DATA_W-1:DATA_W-1];
        w_diff = {1'b0, w_up} - {2'b00, r_dvs};
        w_ge   = ~w_diff[DATA_W+1];
    end

    // Operand latch on init, one restoring step per cycle on step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pr    <= {(2*DATA_W){1'b0}};
            r_dvs   <= {DATA_W{1'b0}};
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (i_init) begin
            r_pr    <= {{DATA_W{1'b0}}, abs_word(i_a, i_signed)};
            r_dvs   <= abs_word(i_b, i_signed);
            r_neg_q <= i_signed & (i_a[DATA_W-1] ^ i_b[DATA_W-1]);
            r_neg_r <= i_signed & i_a[DATA_W-1];
        end else if (i_step) begin
            if (w_ge) begin
                r_pr <= {w_diff[DATA_W-1:0], r_pr[DATA_W-2:0], 1'b1};
            end else begin
                r_pr <= {w_up[DATA_W-1:0], r_pr[DATA_W-2:0], 1'b0};
            end
        end else begin
            r_pr <= r_pr;
        end
    end

    // Quotient negated when operand signs differ; remainder follows dividend.
    always_comb begin
        o_quot = r_neg_q ? neg_word(r_pr[DATA_W-1:0]) : r_pr[DATA_W-1:0];
        o_rem  = r_neg_r ? neg_word(r_pr[2*DATA_W-1:DATA_W]) : r_pr[2*DATA_W-1:DATA_W];
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO producer: executes MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, owns the
// architectural HI/LO registers and stalls the pipeline while a result is
// pending. The result is written at the end of the finishing cycle, the same
// cycle in which the stall drops, so a following MFHI/MFLO sees it in EX.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [2:0]        ex_op,
    input  logic [DATA_W-1:0] ex_src_a,
    input  logic [DATA_W-1:0] ex_src_b,
    input  logic              ex_cancel,
    output logic              stall_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    hilo_state_e         r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_div_signed;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [2*DATA_W-1:0] r_mul_prod;

    hilo_op_e            w_op;
    logic                w_is_mul;
    logic                w_is_div;
    logic                w_idle;
    logic                w_finishing;
    logic                w_mul_sgn;
    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_b_ext;
    logic [2*DATA_W-1:0] w_prod;
    logic                w_div_init;
    logic                w_div_step;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;

    // Op decode, finishing-cycle detect and the multiplier itself.
    always_comb begin
        w_op        = hilo_op_e'(ex_op);
        w_is_mul    = (w_op == OP_MULT) || (w_op == OP_MULTU);
        w_is_div    = (w_op == OP_DIV)  || (w_op == OP_DIVU);
        w_idle      = (r_state == ST_IDLE);
        w_finishing = ((r_state == ST_MUL) && (r_cnt == CNT_W'(MUL_LAT - 1)))
                    || (r_state == ST_DIV_FIX);
        w_mul_sgn   = (w_op == OP_MULT);
        w_a_ext     = {{DATA_W{w_mul_sgn & ex_src_a[DATA_W-1]}}, ex_src_a};
        w_b_ext     = {{DATA_W{w_mul_sgn & ex_src_b[DATA_W-1]}}, ex_src_b};
        w_prod      = w_a_ext * w_b_ext;
        w_div_init  = (r_state == ST_DIV_INIT) && !ex_cancel;
        w_div_step  = (r_state == ST_DIV_ITER) && !ex_cancel;
    end

    // Stall holds IF/ID/EX until the finishing cycle; never during reset.
    always_comb begin
        stall_o = !reset && ex_valid && !ex_cancel &&
                  ((w_idle && (w_is_mul || w_is_div)) || (!w_idle && !w_finishing));
    end

    assign busy_o = r_busy;
    assign hi_o   = r_hi;
    assign lo_o   = r_lo;

    hilo_muldiv_unit_div_iter_core #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .i_init   (w_div_init),
        .i_step   (w_div_step),
        .i_signed (r_div_signed),
        .i_a      (ex_src_a),
        .i_b      (ex_src_b),
        .o_quot   (w_quot),
        .o_rem    (w_rem)
    );

    // Control FSM plus the architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 8'd0;
            r_busy       <= 1'b0;
            r_div_signed <= 1'b0;
            r_hi         <= {DATA_W{1'b0}};
            r_lo         <= {DATA_W{1'b0}};
            r_mul_prod   <= {(2*DATA_W){1'b0}};
        end else if (ex_cancel) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 8'd0;
                    if (ex_valid) begin
                        case (w_op)
                            OP_MULT, OP_MULTU: begin
                                r_state    <= ST_MUL;
                                r_busy     <= 1'b1;
                                r_mul_prod <= w_prod;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_state      <= ST_DIV_INIT;
                                r_busy       <= 1'b1;
                                r_div_signed <= (w_op == OP_DIV);
                            end
                            OP_MTHI: r_hi <= ex_src_a;
                            OP_MTLO: r_lo <= ex_src_a;
                            default: r_state <= ST_IDLE;
                        endcase
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (r_cnt == CNT_W'(MUL_LAT - 1)) begin
                        r_hi    <= r_mul_prod[2*DATA_W-1:DATA_W];
                        r_lo    <= r_mul_prod[DATA_W-1:0];
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DIV_INIT: begin
                    r_state <= ST_DIV_ITER;
                    r_cnt   <= 8'd0;
                end
                ST_DIV_ITER: begin
                    if (r_cnt == CNT_W'(DIV_STEPS - 1)) begin
                        r_state <= ST_DIV_FIX;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DIV_FIX: begin
                    r_lo    <= w_quot;
                    r_hi    <= w_rem;
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

endmodule
